// File: rtl/mem_3in_stream_reader.sv
// Read-side master for a triplet-output memory: one read fetches three
// consecutive words, which are then serialised onto a valid/ready stream.
module mem_3in_stream_reader #(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 128,
  parameter int AW     = $clog2(HEIGHT),
  parameter int CNT_W  = $clog2(HEIGHT) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [AW-1:0]    base_addr,
  input  logic [CNT_W-1:0] num_words,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    mem_read_addr,
  output logic             mem_read_en,
  input  logic [WIDTH-1:0] mem_qout,
  input  logic [WIDTH-1:0] mem_qout_2,
  input  logic [WIDTH-1:0] mem_qout_3,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EMIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [AW-1:0]    curAddr_q, curAddr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       lanes_q, lanes_d;
  logic [1:0]       idx_q, idx_d;
  logic [WIDTH-1:0] word0_q, word0_d;
  logic [WIDTH-1:0] word1_q, word1_d;
  logic [WIDTH-1:0] word2_q, word2_d;
  logic [1:0]       fetchLanes;
  logic [WIDTH-1:0] selWord;

  // The last triplet of a command may be partial; only its valid lanes are emitted.
  assign fetchLanes = (rem_q >= CNT_W'(3)) ? 2'd3 : rem_q[1:0];

  always_comb begin
    state_d   = state_q;
    curAddr_d = curAddr_q;
    rem_d     = rem_q;
    lanes_d   = lanes_q;
    idx_d     = idx_q;
    word0_d   = word0_q;
    word1_d   = word1_q;
    word2_d   = word2_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          curAddr_d = base_addr;
          rem_d     = num_words;
          state_d   = (num_words == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        word0_d   = mem_qout;
        word1_d   = mem_qout_2;
        word2_d   = mem_qout_3;
        lanes_d   = fetchLanes;
        rem_d     = rem_q - {{(CNT_W-2){1'b0}}, fetchLanes};
        idx_d     = 2'd0;
        curAddr_d = curAddr_q + AW'(3);
        state_d   = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          if (idx_q < (lanes_q - 2'd1)) begin
            idx_d = idx_q + 2'd1;
          end else begin
            state_d = (rem_q != '0) ? FETCH : DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      curAddr_q <= '0;
      rem_q     <= '0;
      lanes_q   <= '0;
      idx_q     <= '0;
      word0_q   <= '0;
      word1_q   <= '0;
      word2_q   <= '0;
    end else begin
      state_q   <= state_d;
      curAddr_q <= curAddr_d;
      rem_q     <= rem_d;
      lanes_q   <= lanes_d;
      idx_q     <= idx_d;
      word0_q   <= word0_d;
      word1_q   <= word1_d;
      word2_q   <= word2_d;
    end
  end

  always_comb begin
    case (idx_q)
      2'd0:    selWord = word0_q;
      2'd1:    selWord = word1_q;
      default: selWord = word2_q;
    endcase
  end

  // All outputs decode from registered state, so they settle to zero right after reset.
  assign busy          = (state_q == FETCH) || (state_q == EMIT);
  assign done          = (state_q == DONE);
  assign mem_read_en   = (state_q == FETCH);
  assign mem_read_addr = (state_q == FETCH) ? curAddr_q : '0;
  assign out_valid     = (state_q == EMIT);
  assign out_data      = (state_q == EMIT) ? selWord : '0;
  assign out_last      = (state_q == EMIT) && (rem_q == '0) && (idx_q == (lanes_q - 2'd1));

endmodule
